// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/data arbiter and sequencer for the shared 16-bit system memory.
// Define MEM_ARB_FAIR_EN to add the IF anti-starvation counter (default: fixed data-over-IF priority).
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int WRITE_CYCLES = 2,
    parameter int FAIR_LIMIT   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic [DATA_W-1:0] ifData,
    output logic              ifDone,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWData,
    output logic [DATA_W-1:0] dRData,
    output logic              dDone,
    output logic              busy,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    output logic [1:0]        memRw,
    input  logic [DATA_W-1:0] memRData
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    localparam int WCW = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

    state_t              r_state;
    state_t              w_next;
    logic [WCW-1:0]      r_wcnt;
    logic                r_own_d;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_if_data;
    logic [DATA_W-1:0]   r_d_data;
    logic                r_if_done;
    logic                r_d_done;
    logic                w_if_elig;
    logic                w_d_elig;
    logic                w_force_if;
    logic                w_grant_d;
    logic                w_grant_if;
    logic                w_wr_last;
    logic [1:0]          w_mem_rw;
    logic                w_busy;

    // A port whose done is pulsing is still holding its old request; ignore it this cycle.
    assign w_if_elig  = ifReq & ~r_if_done;
    assign w_d_elig   = dReq & ~r_d_done;
    assign w_grant_d  = (r_state == S_IDLE) & w_d_elig & ~w_force_if;
    assign w_grant_if = (r_state == S_IDLE) & w_if_elig & ~w_grant_d;
    assign w_wr_last  = (r_wcnt == WCW'(WRITE_CYCLES - 1));

`ifdef MEM_ARB_FAIR_EN
    localparam int FCW = $clog2(FAIR_LIMIT + 1);
    logic [FCW-1:0] r_fair_cnt;

    assign w_force_if = w_if_elig & (r_fair_cnt >= FCW'(FAIR_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fair_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_grant_if || !ifReq) begin
                r_fair_cnt <= '0;
            end else if (w_grant_d && w_if_elig) begin
                r_fair_cnt <= r_fair_cnt + FCW'(1);
            end
        end
    end
`else
    assign w_force_if = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    w_next = dWe ? S_WR : S_RD;
                end else if (w_grant_if) begin
                    w_next = S_RD;
                end
            end
            S_RD:    w_next = S_IDLE;
            S_WR:    w_next = w_wr_last ? S_IDLE : S_WR;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_mem_rw = 2'b00;
        w_busy   = 1'b0;
        case (r_state)
            S_RD: begin
                w_mem_rw = 2'b01;
                w_busy   = 1'b1;
            end
            S_WR: begin
                w_mem_rw = 2'b10;
                w_busy   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt    <= '0;
            r_own_d   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_if_data <= '0;
            r_d_data  <= '0;
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wcnt <= '0;
                    if (w_grant_d) begin
                        r_own_d <= 1'b1;
                        r_addr  <= dAddr;
                        if (dWe) begin
                            r_wdata <= dWData;
                        end
                    end else if (w_grant_if) begin
                        r_own_d <= 1'b0;
                        r_addr  <= ifAddr;
                    end
                end
                S_RD: begin
                    if (r_own_d) begin
                        r_d_data <= memRData;
                        r_d_done <= 1'b1;
                    end else begin
                        r_if_data <= memRData;
                        r_if_done <= 1'b1;
                    end
                end
                S_WR: begin
                    if (w_wr_last) begin
                        r_d_done <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + WCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ifData   = r_if_data;
    assign ifDone   = r_if_done;
    assign dRData   = r_d_data;
    assign dDone    = r_d_done;
    assign busy     = w_busy;
    assign memAddr  = r_addr;
    assign memWData = r_wdata;
    assign memRw    = w_mem_rw;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a cycle-level model.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int WC = 2;
    localparam int FL = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ifReq = 1'b0;
    logic [AW-1:0] ifAddr = '0;
    logic [DW-1:0] ifData;
    logic          ifDone;
    logic          dReq = 1'b0;
    logic          dWe = 1'b0;
    logic [AW-1:0] dAddr = '0;
    logic [DW-1:0] dWData = '0;
    logic [DW-1:0] dRData;
    logic          dDone;
    logic          busy;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWData;
    logic [1:0]    memRw;
    logic [DW-1:0] memRData;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        if (a == 16'h0040) return 16'h1234;
        return {a[7:0], a[15:8]} ^ 16'hA5C3;
    endfunction

    assign memRData = mem_f(memAddr);

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WRITE_CYCLES(WC), .FAIR_LIMIT(FL)) dut (
        .clk(clk), .rst(rst),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifData(ifData), .ifDone(ifDone),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWData(dWData), .dRData(dRData), .dDone(dDone),
        .busy(busy), .memAddr(memAddr), .memWData(memWData), .memRw(memRw), .memRData(memRData)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference: an operation in flight is just "cycles of memory activity left" plus its owner.
    int          m_left;
    bit          m_op_d;
    bit          m_op_we;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_if_data;
    logic [15:0] m_d_data;
    bit          m_if_done;
    bit          m_d_done;
    int          m_fair;
    bit          if_pend;
    bit          d_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_left = 0; m_op_d = 0; m_op_we = 0; m_addr = '0; m_wdata = '0;
        m_if_data = '0; m_d_data = '0; m_if_done = 0; m_d_done = 0; m_fair = 0;
        if_pend = 0; d_pend = 0;
    endtask

    task automatic model_step;
        bit nid, ndd, if_el, d_el, force_if, gd, gi;
        nid = 0; ndd = 0; force_if = 0;
        if (m_left > 0) begin
            if (!m_op_we) begin
                if (m_op_d) begin m_d_data = mem_f(m_addr); ndd = 1; end
                else begin m_if_data = mem_f(m_addr); nid = 1; end
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) ndd = 1;
            end
        end else begin
            if_el = ifReq && !m_if_done;
            d_el  = dReq && !m_d_done;
`ifdef MEM_ARB_FAIR_EN
            force_if = if_el && (m_fair >= FL);
`endif
            gd = d_el && !force_if;
            gi = if_el && !gd;
            if (gd) begin
                m_op_d = 1; m_op_we = dWe; m_addr = dAddr;
                if (dWe) m_wdata = dWData;
                m_left = dWe ? WC : 1;
            end else if (gi) begin
                m_op_d = 0; m_op_we = 0; m_addr = ifAddr; m_left = 1;
            end
            if (gi || !ifReq) m_fair = 0;
            else if (gd && if_el) m_fair++;
        end
        m_if_done = nid;
        m_d_done  = ndd;
    endtask

    task automatic check_model;
        logic [1:0] exp_rw;
        exp_rw = (m_left > 0) ? (m_op_we ? 2'b10 : 2'b01) : 2'b00;
        chk("rnd_memRw", 32'(memRw), 32'(exp_rw));
        chk("rnd_busy", 32'(busy), 32'(m_left > 0));
        chk("rnd_ifDone", 32'(ifDone), 32'(m_if_done));
        chk("rnd_dDone", 32'(dDone), 32'(m_d_done));
        chk("rnd_ifData", 32'(ifData), 32'(m_if_data));
        chk("rnd_dRData", 32'(dRData), 32'(m_d_data));
        if (m_left > 0) chk("rnd_memAddr", 32'(memAddr), 32'(m_addr));
        if (m_left > 0 && m_op_we) chk("rnd_memWData", 32'(memWData), 32'(m_wdata));
    endtask

    task automatic drive_random;
        if (m_if_done) if_pend = 0;
        if (!if_pend) begin
            if ($urandom_range(2) == 0) begin
                if_pend = 1; ifReq = 1; ifAddr = 16'($urandom);
            end else begin
                ifReq = 0;
            end
        end else if (m_left > 0 && !m_op_d && $urandom_range(7) == 0) begin
            ifReq = 0;
        end
        if (m_d_done) d_pend = 0;
        if (!d_pend) begin
            if ($urandom_range(2) != 0) begin
                d_pend = 1; dReq = 1; dWe = 1'($urandom_range(1));
                dAddr = 16'($urandom); dWData = 16'($urandom);
            end else begin
                dReq = 0;
            end
        end else if (m_left > 0 && m_op_d && $urandom_range(7) == 0) begin
            dReq = 0;
        end
    endtask

    initial begin
        tick;
        chk("rst_memRw", 32'(memRw), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_memAddr", 32'(memAddr), 32'h0);
        chk("rst_memWData", 32'(memWData), 32'h0);
        chk("rst_ifData", 32'(ifData), 32'h0);
        chk("rst_dRData", 32'(dRData), 32'h0);
        chk("rst_dones", 32'({ifDone, dDone}), 32'h0);
        rst = 0;
        tick;

        // IF read: memRw=01 one cycle after request, done the cycle after that
        ifReq = 1; ifAddr = 16'h0040;
        tick;
        chk("if_rw", 32'(memRw), 32'h1);
        chk("if_addr", 32'(memAddr), 32'h0040);
        chk("if_busy", 32'(busy), 32'h1);
        chk("if_nodone", 32'(ifDone), 32'h0);
        tick;
        chk("if_done", 32'(ifDone), 32'h1);
        chk("if_data", 32'(ifData), 32'h1234);
        chk("if_idle", 32'(memRw), 32'h0);
        ifReq = 0;
        tick;
        chk("if_pulse1", 32'(ifDone), 32'h0);
        chk("if_hold", 32'(ifData), 32'h1234);

        // Write: memRw=10 for WC cycles, dDone exactly once afterwards
        dReq = 1; dWe = 1; dAddr = 16'h8000; dWData = 16'hBEEF;
        tick;
        chk("wr_rw1", 32'(memRw), 32'h2);
        chk("wr_addr", 32'(memAddr), 32'h8000);
        chk("wr_data", 32'(memWData), 32'hBEEF);
        chk("wr_nodone1", 32'(dDone), 32'h0);
        tick;
        chk("wr_rw2", 32'(memRw), 32'h2);
        chk("wr_nodone2", 32'(dDone), 32'h0);
        tick;
        chk("wr_end", 32'(memRw), 32'h0);
        chk("wr_done", 32'(dDone), 32'h1);
        dReq = 0;
        tick;
        chk("wr_pulse1", 32'(dDone), 32'h0);

        // Simultaneous requests: data first, IF granted in the dDone cycle
        ifReq = 1; ifAddr = 16'h0100; dReq = 1; dWe = 0; dAddr = 16'h0200;
        tick;
        chk("both_rw", 32'(memRw), 32'h1);
        chk("both_daddr", 32'(memAddr), 32'h0200);
        tick;
        chk("both_ddone", 32'(dDone), 32'h1);
        chk("both_drdata", 32'(dRData), 32'(mem_f(16'h0200)));
        chk("both_ifwait", 32'(ifDone), 32'h0);
        dReq = 0;
        tick;
        chk("both_ifrw", 32'(memRw), 32'h1);
        chk("both_ifaddr", 32'(memAddr), 32'h0100);
        tick;
        chk("both_ifdone", 32'({ifDone, dDone}), 32'h2);
        chk("both_ifdata", 32'(ifData), 32'(mem_f(16'h0100)));
        ifReq = 0;
        tick;

        // dReq dropped mid-write: write still completes once, no re-issue
        dReq = 1; dWe = 1; dAddr = 16'h1230; dWData = 16'h5555;
        tick;
        chk("drop_rw1", 32'(memRw), 32'h2);
        dReq = 0;
        tick;
        chk("drop_rw2", 32'(memRw), 32'h2);
        tick;
        chk("drop_done", 32'(dDone), 32'h1);
        tick;
        chk("drop_pulse1", 32'(dDone), 32'h0);
        chk("drop_noreissue", 32'(memRw), 32'h0);

        // Reset in the first write cycle: bus idles immediately, op abandoned
        dReq = 1; dWe = 1; dAddr = 16'h4444; dWData = 16'h7777;
        tick;
        chk("rstw_rw", 32'(memRw), 32'h2);
        #2 rst = 1;
        #1;
        chk("rstw_async_rw", 32'(memRw), 32'h0);
        chk("rstw_async_busy", 32'(busy), 32'h0);
        rst = 0; dReq = 0;
        tick;
        chk("rstw_nodone1", 32'(dDone), 32'h0);
        tick;
        chk("rstw_nodone2", 32'(dDone), 32'h0);
        chk("rstw_idle", 32'(busy), 32'h0);

        // Randomized traffic against the reference model
        rst = 1;
        tick;
        model_reset();
        rst = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            drive_random();
            @(posedge clk);
            model_step();
            #1;
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
